// File: rtl/systolic_controller_pkg.sv
// rtl/systolic_controller_pkg.sv - shared state encoding and array-size constants
package systolic_controller_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WEIGHT_LOAD = 3'd1,
    STREAM      = 3'd2,
    DRAIN       = 3'd3,
    DONE        = 3'd4
  } state_t;

  localparam int DEF_ARRAY_HEIGHT = 4;
  localparam int DEF_ARRAY_WIDTH  = 4;
  localparam int DEF_COUNT_WIDTH  = 16;
  localparam int DEF_WADDR_WIDTH  = 2;

  function automatic int array_latency(input int h, input int w);
    return h + w - 1;
  endfunction

  localparam int ARRAY_LATENCY = array_latency(DEF_ARRAY_HEIGHT, DEF_ARRAY_WIDTH);

endpackage

// File: rtl/systolic_controller_stall_gated_counter.sv
// rtl/systolic_controller_stall_gated_counter.sv - loadable up-counter with enable and terminal flag
module stall_gated_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_terminal,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // Load has priority so a clear can coincide with the final increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_terminal);

endmodule

// File: rtl/systolic_controller.sv
// rtl/systolic_controller.sv - sequences weight load, ifmap streaming and ofmap writes for one pass
module systolic_controller
  import systolic_controller_pkg::*;
#(
  parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
  parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int WADDR_WIDTH  = DEF_WADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_vectors,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   weight_rd_en,
  output logic [WADDR_WIDTH-1:0] weight_rd_addr,
  output logic                   weight_write_enable,
  output logic                   ifmap_rd_en,
  output logic [COUNT_WIDTH-1:0] ifmap_rd_addr,
  output logic                   enable,
  output logic                   ofmap_wr_en,
  output logic [COUNT_WIDTH-1:0] ofmap_wr_addr
);

  localparam int WCW = WADDR_WIDTH + 1;
  localparam int CW1 = COUNT_WIDTH + 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(ARRAY_HEIGHT);
  localparam logic [CW1-1:0] LAT_C  = CW1'(array_latency(ARRAY_HEIGHT, ARRAY_WIDTH));

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_num;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_weight_rd_en;
  logic                   r_weight_we;
  logic [COUNT_WIDTH-1:0] r_ofmap_addr;

  logic                   w_start_ok;
  logic                   w_enable;
  logic                   w_ifmap_rd;
  logic                   w_ofmap_wr;
  logic [WCW-1:0]         w_wrow;
  logic                   w_wrow_tc;
  logic [COUNT_WIDTH-1:0] w_iaddr;
  logic                   w_iaddr_tc;
  logic [CW1-1:0]         w_cyc;
  logic                   w_cyc_tc;
  logic [CW1-1:0]         w_num_ext;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_num_ext  = {1'b0, r_num};
  assign w_enable   = ((r_state == STREAM) || (r_state == DRAIN)) && !stall;
  assign w_ifmap_rd = (r_state == STREAM) && !stall;
  // Results emerge L enabled cycles after their vector entered, one cycle after the read.
  assign w_ofmap_wr = w_enable && (w_cyc > LAT_C) && (w_cyc <= w_num_ext + LAT_C);

  stall_gated_counter #(.WIDTH(WCW)) u_weight_row (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_ok || ((r_state == WEIGHT_LOAD) && w_wrow_tc)),
    .i_load_val ('0),
    .i_en       (r_state == WEIGHT_LOAD),
    .i_terminal (W_LAST),
    .o_count    (w_wrow),
    .o_tc       (w_wrow_tc)
  );

  stall_gated_counter #(.WIDTH(COUNT_WIDTH)) u_ifmap_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_ok || (w_ifmap_rd && w_iaddr_tc)),
    .i_load_val ('0),
    .i_en       (w_ifmap_rd),
    .i_terminal (r_num - COUNT_WIDTH'(1)),
    .o_count    (w_iaddr),
    .o_tc       (w_iaddr_tc)
  );

  // One bit wider than the vector count so N + L never wraps.
  stall_gated_counter #(.WIDTH(CW1)) u_enabled_cycles (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_ok),
    .i_load_val ('0),
    .i_en       (w_enable),
    .i_terminal (w_num_ext + LAT_C),
    .o_count    (w_cyc),
    .o_tc       (w_cyc_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_num          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_weight_rd_en <= 1'b0;
      r_weight_we    <= 1'b0;
      r_ofmap_addr   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (num_vectors != '0) begin
              r_num          <= num_vectors;
              r_weight_rd_en <= 1'b1;
              r_state        <= WEIGHT_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WEIGHT_LOAD: begin
          r_weight_rd_en <= (w_wrow + WCW'(1)) < W_LAST;
          r_weight_we    <= !w_wrow_tc;
          if (w_wrow_tc) r_state <= STREAM;
        end
        STREAM: begin
          if (w_ifmap_rd && w_iaddr_tc) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_enable && w_cyc_tc) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_ofmap_wr) begin
        r_ofmap_addr <= r_ofmap_addr + COUNT_WIDTH'(1);
      end else if (w_start_ok) begin
        r_ofmap_addr <= '0;
      end
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign weight_rd_en        = r_weight_rd_en;
  assign weight_rd_addr      = w_wrow[WADDR_WIDTH-1:0];
  assign weight_write_enable = r_weight_we;
  assign ifmap_rd_en         = w_ifmap_rd;
  assign ifmap_rd_addr       = w_iaddr;
  assign enable              = w_enable;
  assign ofmap_wr_en         = w_ofmap_wr;
  assign ofmap_wr_addr       = r_ofmap_addr;

endmodule

// File: doc/systolic_controller.md
Name: systolic_controller

Overview:
Sequences one pass through a systolic array of mac cells (ARRAY_HEIGHT x ARRAY_WIDTH).
- Loads weights row by row through the cells' weight_write_enable path.
- Streams num_vectors ifmap vectors from the ifmap buffer.
- Drives the array-wide enable and tells the ofmap buffer when and where to write each result vector.
- Sits between the top-level accelerator FSM (start/done) and the weight, ifmap and ofmap buffer read/write ports.

Parameters:
ARRAY_HEIGHT, 4, rows of mac cells (weight rows to load)
ARRAY_WIDTH, 4, columns of mac cells
COUNT_WIDTH, 16, width of vector count and ifmap/ofmap addresses
WADDR_WIDTH, 2, weight buffer address width, equal to clog2(ARRAY_HEIGHT)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a pass; sampled in IDLE only
num_vectors  input  COUNT_WIDTH  ifmap vectors for this pass; latched on accepted start
stall  input  1  downstream back-pressure; freezes streaming while high
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of pass
weight_rd_en  output  1  weight buffer read strobe
weight_rd_addr  output  WADDR_WIDTH  weight row address
weight_write_enable  output  1  to all mac cells: shift weight row in
ifmap_rd_en  output  1  ifmap buffer read strobe
ifmap_rd_addr  output  COUNT_WIDTH  ifmap vector address
enable  output  1  to all mac cells: advance pipeline
ofmap_wr_en  output  1  ofmap buffer write strobe
ofmap_wr_addr  output  COUNT_WIDTH  ofmap vector address

Behaviour:
- Reset: async. State goes to IDLE; all counters and all outputs are 0. Reset mid-pass aborts immediately and leaves no residual strobes.
- Buffer contract: weight and ifmap buffers have 1-cycle read latency. The ifmap buffer holds its read data until the next ifmap_rd_en.
- L = ARRAY_HEIGHT + ARRAY_WIDTH - 1 is the array latency in enabled cycles.
- States: IDLE, WEIGHT_LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 and num_vectors>0: latch N = num_vectors, go to WEIGHT_LOAD.
  - start=1 and num_vectors=0: go to DONE.
  - start in any other state is ignored. num_vectors changes after latch have no effect.
- WEIGHT_LOAD: lasts ARRAY_HEIGHT+1 cycles and is not affected by stall.
  - Cycles 0..H-1: weight_rd_en=1, weight_rd_addr = cycle index.
  - Cycles 1..H: weight_write_enable=1 (one cycle behind the read).
  - Then go to STREAM.
- Enabled cycle counter c counts cycles with enable=1, starting from STREAM entry.
- STREAM:
  - enable = !stall; ifmap_rd_en = !stall.
  - ifmap_rd_addr runs 0..N-1 and advances only on non-stalled cycles.
  - After the read of address N-1, go to DRAIN.
- DRAIN: enable = !stall; no reads. Exit to DONE once c reaches N+1+L.
- ofmap writes (STREAM and DRAIN): ofmap_wr_en=1 on enabled cycles where 1+L <= c < N+1+L, with ofmap_wr_addr = c-1-L.
- Stall timing: enable, ifmap_rd_en and ofmap_wr_en are combinationally gated by stall in the same cycle. All other outputs are registered. Stall during WEIGHT_LOAD, IDLE or DONE has no effect.
- DONE: done=1 for one cycle, busy=1, then go to IDLE. A start in that cycle is ignored.
- Counter widths: COUNT_WIDTH. N up to 2^COUNT_WIDTH-1 must work; the drain counter is one bit wider than COUNT_WIDTH so it never wraps.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WEIGHT_LOAD, STREAM, DRAIN, DONE)
  - array-size defaults
  - latency constant L = ARRAY_HEIGHT + ARRAY_WIDTH - 1
- The single natural sub-module is stall_gated_counter: loadable up-counter with enable and terminal-count flag. Instantiated for the weight row, ifmap address and enabled-cycle counters.

Test Plan:
(H=W=4, L=7, start asserted in cycle 0)
1. Reset -> all outputs 0 during and after reset; busy=0; no strobes for 10 idle cycles.
2. start, N=3, stall=0 ->
   - weight_rd_en cycles 1-4, addr 0..3; weight_write_enable cycles 2-5.
   - ifmap_rd_en cycles 6-8, addr 0..2; enable cycles 6-16.
   - ofmap_wr_en cycles 14-16, addr 0..2; done in cycle 17; busy cycles 1-17.
3. Same as 2 with stall=1 in cycles 7-8 -> in those cycles enable=0 and ifmap_rd_en=0, with ifmap_rd_addr held at 1. ofmap_wr_en moves to cycles 16-18 (addr 0..2) and done to cycle 19.
4. start re-pulsed in cycle 5 with num_vectors=9 during a N=3 run -> ignored; behaviour identical to scenario 2.
5. start with num_vectors=0 -> done in cycle 1, busy only in cycle 1; no read, write, enable or weight strobes.
6. rst_n low in cycle 10 of scenario 2 -> all outputs 0 immediately. A new start with N=1 then completes cleanly: ofmap_wr_en once at addr 0, done 15 cycles after that start.
